card_dispatch: RTL
==================

CARD_DISPATCH -- requirements
Module: card_dispatch

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: request FIFO entries; power of two, 2..16.
REQ-002 Parameter X_BASE, default 4: x of slot 0 card origin.
REQ-003 Parameter X_STEP, default 14: x pitch between slots.
REQ-004 Parameter PLAYER_Y, default 90; DEALER_Y, default 20: y of card origin per hand.
REQ-005 Parameter MAX_SLOTS, default 8: cards per hand; X_BASE+(MAX_SLOTS-1)*X_STEP+11 SHALL be <160.
REQ-006 clk  in  1  single clock; all state on posedge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 new_round  in  1  one-cycle pulse: flush, clear slots, queue table init.
REQ-009 req_valid  in  1  card draw request valid.
REQ-010 req_card  in  6  card code: [5:2] rank 0..12, [1:0] suit.
REQ-011 req_who  in  1  0 player, 1 dealer.
REQ-012 req_ready  out  1  request accepted when req_valid&&req_ready.
REQ-013 pr_write  out  1  command strobe to print engine.
REQ-014 pr_init  out  1  1 = table init command, 0 = card command.
REQ-015 pr_card  out  6  card code of command.
REQ-016 pr_orig  out  15  card origin {x[7:0], y[6:0]}.
REQ-017 pr_waitrequest  in  1  print engine busy.
REQ-018 cmd_done  out  1  one-cycle pulse per completed command.
REQ-019 bad_card, hand_full, timeout_err  out  1 each  sticky error flags.

Function
REQ-020 req_ready SHALL equal !fifo_full && !new_round; new_round with req_valid drops the request.
REQ-021 On accept: rank>12 SHALL drop the request and set bad_card; else if slot counter of req_who ==MAX_SLOTS, drop and set hand_full; else push {card, orig} with orig x=X_BASE+slot*X_STEP, y per hand, and increment that slot counter.
REQ-022 Slot counters (one per hand, 0..MAX_SLOTS) SHALL be 8-bit-safe; orig arithmetic truncated to 8/7 bits after range check.
REQ-023 States: IDLE, ISSUE, GAP, WAIT.
REQ-024 IDLE: if pr_waitrequest==0 and init_pending, load pr_init=1, pr_card=0, pr_orig=0, clear init_pending; else if pr_waitrequest==0 and FIFO non-empty, pop and load pr_init=0, pr_card/pr_orig from head; in both cases pr_write<=1, go ISSUE.
REQ-025 Pending init SHALL take priority over FIFO entries.
REQ-026 ISSUE: pr_write<=0, go GAP (pr_write high exactly one cycle per command).
REQ-027 GAP: pr_waitrequest ignored for one cycle, go WAIT (engine raises busy one cycle after strobe).
REQ-028 WAIT: when pr_waitrequest==0, pulse cmd_done, return IDLE; next issue no earlier than the following cycle.
REQ-029 pr_init/pr_card/pr_orig SHALL hold their values from ISSUE until the next load.
REQ-030 new_round: FIFO flushed, both slot counters cleared, init_pending set, same cycle; an in-flight command completes normally.
REQ-031 FIFO push and pop in the same cycle SHALL both take effect; count unchanged when full.
REQ-032 Error flags cleared only by rst.

Reset
REQ-033 On rst: state IDLE, FIFO empty, slot counters 0, init_pending 1, pr_write 0, pr_init 0, pr_card 0, pr_orig 0, cmd_done 0, all error flags 0.
REQ-034 rst mid-command SHALL abandon it immediately; no further strobe until pr_waitrequest==0.

Configuration
REQ-035 Macro CARD_DISPATCH_TIMEOUT_EN defined: 16-bit counter in WAIT; if pr_waitrequest stays high 32768 cycles, set timeout_err, go IDLE, no cmd_done.
REQ-036 Macro undefined: no counter, WAIT unbounded, timeout_err tied 0.

Verification
REQ-037 rst, engine idle -> first strobe pr_init=1 one cycle after rst release; cmd_done after waitrequest falls.
REQ-038 Push player 0x05, 0x09, dealer 0x30 -> pr_orig {4,90}, {18,90}, {4,20} in order, one strobe each.
REQ-039 Push req_card=0x34 (rank 13) -> not queued, bad_card=1, no strobe.
REQ-040 Nine player pushes -> eight strobes, ninth dropped, hand_full=1, last orig x=102.
REQ-041 new_round during card command with 3 queued -> in-flight finishes, queue discarded, next strobe pr_init=1, next player card x=4.
REQ-042 TIMEOUT_EN, waitrequest held high -> timeout_err=1 after 32768 WAIT cycles, state IDLE.

Source files
------------

// File: rtl/card_dispatch.sv
// Card draw dispatcher: turns card requests into slot-placed print commands for a print engine.
// Optional macro CARD_DISPATCH_TIMEOUT_EN adds a WAIT-state watchdog driving timeout_err.
module card_dispatch #(
  parameter int FIFO_DEPTH = 4,
  parameter int X_BASE     = 4,
  parameter int X_STEP     = 14,
  parameter int PLAYER_Y   = 90,
  parameter int DEALER_Y   = 20,
  parameter int MAX_SLOTS  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_round,
  input  logic        req_valid,
  input  logic [5:0]  req_card,
  input  logic        req_who,
  output logic        req_ready,
  output logic        pr_write,
  output logic        pr_init,
  output logic [5:0]  pr_card,
  output logic [14:0] pr_orig,
  input  logic        pr_waitrequest,
  output logic        cmd_done,
  output logic        bad_card,
  output logic        hand_full,
  output logic        timeout_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = 21;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_WAIT} state_t;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [7:0]    slot_q [2];
  logic          init_pending_q;
  logic          bad_card_q, hand_full_q;
  state_t        state_q;
  logic          pr_write_q, pr_init_q, cmd_done_q;
  logic [5:0]    pr_card_q;
  logic [14:0]   pr_orig_q;

  logic          fifo_full, fifo_empty;
  logic          accept, rank_bad, slot_at_max, push, pop;
  logic          issue_init, issue_card;
  logic [7:0]    slot_sel, x_pos;
  logic [6:0]    y_pos;
  logic [EW-1:0] head;

  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign req_ready  = !fifo_full && !new_round;
  assign accept     = req_valid && req_ready;

  assign rank_bad    = (req_card[5:2] > 4'd12);
  assign slot_sel    = slot_q[req_who];
  assign slot_at_max = (slot_sel == 8'(MAX_SLOTS));
  assign push        = accept && !rank_bad && !slot_at_max;

  // Origin arithmetic is safe to truncate: the slot is range-checked first.
  assign x_pos = 8'(X_BASE) + slot_sel * 8'(X_STEP);
  assign y_pos = req_who ? 7'(DEALER_Y) : 7'(PLAYER_Y);

  // A new_round in IDLE issues the init directly rather than a card that is being flushed.
  assign issue_init = (state_q == S_IDLE) && !pr_waitrequest && (init_pending_q || new_round);
  assign issue_card = (state_q == S_IDLE) && !pr_waitrequest && !init_pending_q && !new_round
                      && !fifo_empty;
  assign pop  = issue_card;
  assign head = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_card, x_pos, y_pos};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || new_round) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (rst || new_round) begin
          slot_q[gi] <= '0;
        end else if (push && (req_who == 1'(gi))) begin
          slot_q[gi] <= slot_q[gi] + 8'd1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      init_pending_q <= 1'b1;
      bad_card_q     <= 1'b0;
      hand_full_q    <= 1'b0;
    end else begin
      if (issue_init)     init_pending_q <= 1'b0;
      else if (new_round) init_pending_q <= 1'b1;
      if (accept && rank_bad)                bad_card_q  <= 1'b1;
      if (accept && !rank_bad && slot_at_max) hand_full_q <= 1'b1;
    end
  end

`ifdef CARD_DISPATCH_TIMEOUT_EN
  logic [15:0] wait_cnt_q;
  logic        timeout_err_q;
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pr_write_q <= 1'b0;
      pr_init_q  <= 1'b0;
      pr_card_q  <= '0;
      pr_orig_q  <= '0;
      cmd_done_q <= 1'b0;
`ifdef CARD_DISPATCH_TIMEOUT_EN
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      pr_write_q <= 1'b0;
      cmd_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (issue_init) begin
            pr_write_q <= 1'b1;
            pr_init_q  <= 1'b1;
            pr_card_q  <= '0;
            pr_orig_q  <= '0;
            state_q    <= S_ISSUE;
          end else if (issue_card) begin
            pr_write_q <= 1'b1;
            pr_init_q  <= 1'b0;
            pr_card_q  <= head[20:15];
            pr_orig_q  <= head[14:0];
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: state_q <= S_GAP;
        // The engine only raises busy a cycle after the strobe, so skip sampling it here.
        S_GAP: begin
          state_q <= S_WAIT;
`ifdef CARD_DISPATCH_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        S_WAIT: begin
          if (!pr_waitrequest) begin
            cmd_done_q <= 1'b1;
            state_q    <= S_IDLE;
          end
`ifdef CARD_DISPATCH_TIMEOUT_EN
          else if (wait_cnt_q == 16'h7FFF) begin
            timeout_err_q <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pr_write  = pr_write_q;
  assign pr_init   = pr_init_q;
  assign pr_card   = pr_card_q;
  assign pr_orig   = pr_orig_q;
  assign cmd_done  = cmd_done_q;
  assign bad_card  = bad_card_q;
  assign hand_full = hand_full_q;

endmodule
